// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the fetch redirect controller: direction-counter states
// and the layout of one in-flight prediction queue entry.
package fetch_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_state_t;

    // MSB-first: taken flag, uncond flag, predicted target, fallthrough PC.
    typedef struct packed {
        logic        taken;
        logic        uncond;
        logic [31:0] target;
        logic [31:0] fall;
    } q_entry_t;

    localparam int ENTRY_W = $bits(q_entry_t);

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Fetch, prediction and resolve signals of fetch_redirect_ctrl.
// The slave modport is the controller; master is the surrounding pipeline.
interface fetch_redirect_ctrl_if;
    logic        stall_i;
    logic        fetch_ready_i;
    logic [31:0] pc_o;
    logic        fetch_valid_o;
    logic        pred_is_branch_i;
    logic        pred_uncond_i;
    logic [31:0] pred_target_i;
    logic        taken_pred_o;
    logic        res_valid_i;
    logic        res_taken_i;
    logic [31:0] res_target_i;
    logic        flush_o;
    logic        miss_pred_o;
    logic        queue_full_o;

    modport master (
        output stall_i, fetch_ready_i, pred_is_branch_i, pred_uncond_i, pred_target_i,
               res_valid_i, res_taken_i, res_target_i,
        input  pc_o, fetch_valid_o, taken_pred_o, flush_o, miss_pred_o, queue_full_o
    );

    modport slave (
        input  stall_i, fetch_ready_i, pred_is_branch_i, pred_uncond_i, pred_target_i,
               res_valid_i, res_taken_i, res_target_i,
        output pc_o, fetch_valid_o, taken_pred_o, flush_o, miss_pred_o, queue_full_o
    );
endinterface

// File: rtl/fetch_redirect_ctrl_br_pred_queue.sv
// FIFO of in-flight predicted branches, oldest entry presented on head.
// Clear has priority over push and pop in the same cycle.
module br_pred_queue
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  q_entry_t                 push_data,
    input  logic                     pop,
    output q_entry_t                 head,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);

    q_entry_t          mem [DEPTH];
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == (PW+1)'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & (count_reg != '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (PW+1)'(1);
                2'b01:   count_reg <= count_reg - (PW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end
endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer with 2-bit direction counter and misprediction redirect.
// Optional FETCH_STATS_EN adds resolved-branch and mispredict counters.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    fetch_redirect_ctrl_if.slave  bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]           stat_branches_o,
    output logic [31:0]           stat_misses_o
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0] pc_reg, pc_next;
    logic        valid_reg;
    logic        flush_reg;
    ctr_state_t  ctr_reg, ctr_next;

    q_entry_t    head;
    q_entry_t    push_data;
    logic        q_full;
    logic [CW-1:0] q_count;

    logic        taken_pred;
    logic        advance;
    logic        pop_fire;
    logic        mispredict;
    logic [31:0] fallthrough;
    logic [31:0] actual;
    logic [31:0] predicted;

    assign taken_pred  = bus.pred_is_branch_i & (bus.pred_uncond_i | ctr_reg[1]);
    // A full queue stalls any branch fetch, even if a pop frees a slot this cycle.
    assign advance     = valid_reg & bus.fetch_ready_i & ~bus.stall_i
                         & ~(bus.pred_is_branch_i & q_full);
    assign pop_fire    = bus.res_valid_i & (q_count != '0);
    assign actual      = bus.res_taken_i ? bus.res_target_i : head.fall;
    assign predicted   = head.taken ? head.target : head.fall;
    assign mispredict  = pop_fire & (actual != predicted);
    assign fallthrough = pc_reg + 32'd4;

    assign push_data = '{taken: taken_pred, uncond: bus.pred_uncond_i,
                         target: bus.pred_target_i, fall: fallthrough};

    br_pred_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (mispredict),
        .push      (advance & bus.pred_is_branch_i),
        .push_data (push_data),
        .pop       (pop_fire),
        .head      (head),
        .full      (q_full),
        .count     (q_count)
    );

    // Redirect beats everything, including stall and a same-cycle fetch.
    always_comb begin
        pc_next = pc_reg;
        if (mispredict)
            pc_next = actual;
        else if (advance)
            pc_next = taken_pred ? bus.pred_target_i : fallthrough;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_reg    <= RESET_PC;
            valid_reg <= 1'b0;
            flush_reg <= 1'b0;
            ctr_reg   <= WNT;
        end else begin
            pc_reg    <= pc_next;
            valid_reg <= 1'b1;
            flush_reg <= mispredict;
            ctr_reg   <= ctr_next;
        end
    end

    // Only conditional branches train the counter; JAL entries leave it alone.
    always_comb begin
        ctr_next = ctr_reg;
        if (pop_fire && !head.uncond) begin
            case (ctr_reg)
                SNT:     ctr_next = bus.res_taken_i ? WNT : SNT;
                WNT:     ctr_next = bus.res_taken_i ? WT  : SNT;
                WT:      ctr_next = bus.res_taken_i ? ST  : WNT;
                ST:      ctr_next = bus.res_taken_i ? ST  : WT;
                default: ctr_next = WNT;
            endcase
        end
    end

    assign bus.pc_o          = pc_reg;
    assign bus.fetch_valid_o = valid_reg;
    assign bus.taken_pred_o  = taken_pred;
    assign bus.flush_o       = flush_reg;
    assign bus.miss_pred_o   = flush_reg;
    assign bus.queue_full_o  = q_full;

`ifdef FETCH_STATS_EN
    logic [31:0] branches_reg;
    logic [31:0] misses_reg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            branches_reg <= '0;
            misses_reg   <= '0;
        end else begin
            if (pop_fire)   branches_reg <= branches_reg + 32'd1;
            if (mispredict) misses_reg   <= misses_reg + 32'd1;
        end
    end

    assign stat_branches_o = branches_reg;
    assign stat_misses_o   = misses_reg;
`endif
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios with literal expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_fetch_redirect_ctrl;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fetch_redirect_ctrl_if bus ();

`ifdef FETCH_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_misses;
`endif

    fetch_redirect_ctrl #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
`ifdef FETCH_STATS_EN
        ,
        .stat_branches_o (stat_branches),
        .stat_misses_o   (stat_misses)
`endif
    );

    typedef struct {
        bit          tk;
        bit          un;
        logic [31:0] tgt;
        logic [31:0] fall;
    } ent_t;

    // Model state
    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_flush;
    int          m_cnt;
    logic [31:0] m_br;
    logic [31:0] m_ms;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    task automatic set_in(bit st, bit rdy, bit br, bit un, logic [31:0] tgt,
                          bit rv, bit rt, logic [31:0] rtg);
        bus.stall_i          = st;
        bus.fetch_ready_i    = rdy;
        bus.pred_is_branch_i = br;
        bus.pred_uncond_i    = un;
        bus.pred_target_i    = tgt;
        bus.res_valid_i      = rv;
        bus.res_taken_i      = rt;
        bus.res_target_i     = rtg;
    endtask

    // Advance one clock; the model's next state is computed from the
    // current inputs and committed just after the edge.
    task automatic step();
        ent_t        q2[$];
        ent_t        e;
        logic [31:0] npc, act, prd, nb, nm;
        bit          nv, tk, adv, mis;
        int          nc;
        q2 = mq; npc = m_pc; nc = m_cnt; nb = m_br; nm = m_ms; mis = 1'b0; nv = 1'b1;
        if (!reset_n) begin
            q2.delete(); npc = RPC; nv = 1'b0; nc = 1; nb = '0; nm = '0;
        end else begin
            tk  = bus.pred_is_branch_i && (bus.pred_uncond_i || m_cnt >= 2);
            adv = m_valid && bus.fetch_ready_i && !bus.stall_i
                  && !(bus.pred_is_branch_i && mq.size() == DEPTH);
            if (bus.res_valid_i && q2.size() > 0) begin
                e   = q2.pop_front();
                act = bus.res_taken_i ? bus.res_target_i : e.fall;
                prd = e.tk ? e.tgt : e.fall;
                mis = (act != prd);
                if (!e.un)
                    nc = bus.res_taken_i ? ((nc < 3) ? nc + 1 : 3) : ((nc > 0) ? nc - 1 : 0);
                nb = nb + 32'd1;
            end
            if (mis) begin
                q2.delete();
                npc = act;
                nm  = nm + 32'd1;
            end else if (adv) begin
                if (bus.pred_is_branch_i)
                    q2.push_back('{tk, bus.pred_uncond_i, bus.pred_target_i, m_pc + 32'd4});
                npc = tk ? bus.pred_target_i : m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
        mq = q2; m_pc = npc; m_valid = nv; m_flush = mis; m_cnt = nc; m_br = nb; m_ms = nm;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", bus.pc_o, m_pc);
            check("fetch_valid", 32'(bus.fetch_valid_o), 32'(m_valid));
            check("flush", 32'(bus.flush_o), 32'(m_flush));
            check("miss_pred", 32'(bus.miss_pred_o), 32'(m_flush));
            check("queue_full", 32'(bus.queue_full_o), 32'(mq.size() == DEPTH));
            check("taken_pred", 32'(bus.taken_pred_o),
                  32'(bus.pred_is_branch_i && (bus.pred_uncond_i || m_cnt >= 2)));
`ifdef FETCH_STATS_EN
            check("stat_branches", stat_branches, m_br);
            check("stat_misses", stat_misses, m_ms);
`endif
        end
    end

    initial begin
        bit          st, rdy, br, un, rv, rt;
        logic [31:0] tgt, rtg;

        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        step();
        check("lit_reset_pc", bus.pc_o, 32'h100);
        check("lit_reset_valid", 32'(bus.fetch_valid_o), 32'd0);
        check("lit_reset_flush", 32'(bus.flush_o), 32'd0);

        // Release: valid rises, then sequential fetch
        reset_n = 1'b1;
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("lit_valid_after_reset", 32'(bus.fetch_valid_o), 32'd1);
        check("lit_pc_first", bus.pc_o, 32'h100);
        step();
        check("lit_pc_seq1", bus.pc_o, 32'h104);
        step();
        check("lit_pc_seq2", bus.pc_o, 32'h108);

        // JAL to 0x200, resolved correctly
        set_in(0, 1, 1, 1, 32'h200, 0, 0, 0);
        #1 check("lit_jal_taken", 32'(bus.taken_pred_o), 32'd1);
        step();
        check("lit_pc_jal", bus.pc_o, 32'h200);
        set_in(0, 0, 0, 0, 0, 1, 1, 32'h200);
        step();
        check("lit_jal_noflush", 32'(bus.flush_o), 32'd0);

        // WNT branch at 0x200 -> not taken; resolve not-taken -> SNT
        set_in(0, 1, 1, 0, 32'h180, 0, 0, 0);
        #1 check("lit_wnt_pred", 32'(bus.taken_pred_o), 32'd0);
        step();
        check("lit_pc_204", bus.pc_o, 32'h204);
        set_in(0, 0, 0, 0, 0, 1, 0, 32'h180);
        step();
        check("lit_nt_noflush", 32'(bus.flush_o), 32'd0);

        // JAL to 0x40, then JAL at 0x40 to 0x80 with counter SNT
        set_in(0, 1, 1, 1, 32'h40, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 1, 32'h40);
        step();
        set_in(0, 1, 1, 1, 32'h80, 0, 0, 0);
        #1 check("lit_jal_snt_taken", 32'(bus.taken_pred_o), 32'd1);
        step();
        check("lit_pc_80", bus.pc_o, 32'h80);
        set_in(0, 0, 0, 0, 0, 1, 1, 32'h80);
        step();
        check("lit_jal80_noflush", 32'(bus.flush_o), 32'd0);

        // Counter still SNT; two taken mispredicts walk it to WT
        set_in(0, 1, 1, 0, 32'h90, 0, 0, 0);
        #1 check("lit_snt_kept", 32'(bus.taken_pred_o), 32'd0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 1, 32'h90);
        step();
        check("lit_miss1_flush", 32'(bus.flush_o), 32'd1);
        check("lit_miss1_pc", bus.pc_o, 32'h90);
        set_in(0, 1, 1, 0, 32'h300, 0, 0, 0);
        step();
        set_in(0, 0, 0, 0, 0, 1, 1, 32'h300);
        step();
        check("lit_pc_300", bus.pc_o, 32'h300);

        // WT branch at 0x300 -> 0x400, resolved not taken
        set_in(0, 1, 1, 0, 32'h400, 0, 0, 0);
        #1 check("lit_wt_pred", 32'(bus.taken_pred_o), 32'd1);
        step();
        check("lit_pc_400", bus.pc_o, 32'h400);
        set_in(0, 0, 0, 0, 0, 1, 0, 32'h0);
        step();
        check("lit_wt_miss_flush", 32'(bus.flush_o), 32'd1);
        check("lit_wt_miss_pulse", 32'(bus.miss_pred_o), 32'd1);
        check("lit_wt_miss_pc", bus.pc_o, 32'h304);
        check("lit_wt_miss_empty", 32'(bus.queue_full_o), 32'd0);

        // Fill the queue, fifth branch holds, non-branch advances
        set_in(0, 1, 1, 0, 32'h700, 0, 0, 0);
        #1 check("lit_wnt_again", 32'(bus.taken_pred_o), 32'd0);
        for (int i = 0; i < DEPTH; i++) step();
        check("lit_full", 32'(bus.queue_full_o), 32'd1);
        check("lit_pc_314", bus.pc_o, 32'h314);
        step();
        check("lit_full_hold", bus.pc_o, 32'h314);
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        step();
        check("lit_nonbranch_adv", bus.pc_o, 32'h318);
        set_in(0, 1, 1, 0, 32'h700, 1, 0, 0);
        step();
        check("lit_full_pop_hold", bus.pc_o, 32'h318);
        check("lit_unblocked", 32'(bus.queue_full_o), 32'd0);
        set_in(0, 1, 1, 0, 32'h700, 0, 0, 0);
        step();
        check("lit_pc_31c", bus.pc_o, 32'h31c);

        // Mispredict while stalled with a branch presented
        set_in(1, 1, 1, 0, 32'h700, 1, 1, 32'h500);
        step();
        check("lit_stall_redirect_pc", bus.pc_o, 32'h500);
        check("lit_stall_redirect_flush", 32'(bus.flush_o), 32'd1);
        check("lit_stall_redirect_empty", 32'(bus.queue_full_o), 32'd0);

        // Mispredict with an unstalled push in the same cycle: push discarded
        set_in(0, 1, 1, 0, 32'h600, 0, 0, 0);
        step();
        set_in(0, 1, 1, 0, 32'h800, 1, 1, 32'h600);
        step();
        check("lit_push_discard_pc", bus.pc_o, 32'h600);
        set_in(0, 0, 1, 0, 32'h0, 1, 1, 32'h999);
        #1 check("lit_wt_after", 32'(bus.taken_pred_o), 32'd1);
        step();
        check("lit_empty_resolve_noflush", 32'(bus.flush_o), 32'd0);
        check("lit_empty_resolve_pc", bus.pc_o, 32'h600);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n = ($urandom_range(0, 299) != 0);
            st  = ($urandom_range(0, 4) == 0);
            rdy = ($urandom_range(0, 4) != 0);
            br  = ($urandom_range(0, 2) == 0);
            un  = ($urandom_range(0, 3) == 0);
            tgt = $urandom() & 32'hffff_fffc;
            rv  = ($urandom_range(0, 3) == 0);
            rt  = 1'($urandom_range(0, 1));
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rtg = mq[0].tgt;
            else
                rtg = $urandom() & 32'hffff_fffc;
            set_in(st, rdy, br, un, tgt, rv, rt, rtg);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Owns the fetch PC register and sequences the next PC from four sources: misprediction redirect, stall hold, predicted-taken target, and sequential PC+4. It takes the decoded branch/target information from the fetch-stage predictor and supplies the taken/not-taken decision from a 2-bit saturating counter. A FIFO holds every in-flight predicted branch until execute resolves it. On a mismatch the block raises a one-cycle flush and redirects fetch.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded while reset_n is low
DEPTH, 4, prediction queue entries (power of 2, >=2)

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
stall_i  in  1  hold PC (decode/hazard stall)
fetch_ready_i  in  1  instruction memory accepted pc_o
pc_o  out  32  current fetch PC
fetch_valid_o  out  1  pc_o valid for instruction memory
pred_is_branch_i  in  1  fetched instruction is a conditional branch or JAL
pred_uncond_i  in  1  fetched instruction is JAL (always taken)
pred_target_i  in  32  decoded PC-relative target
taken_pred_o  out  1  prediction applied to the current fetch
res_valid_i  in  1  execute resolves the oldest branch this cycle
res_taken_i  in  1  actual direction
res_target_i  in  32  actual target
flush_o  out  1  one-cycle flush of the IF/ID/EX wrong path
miss_pred_o  out  1  one-cycle misprediction pulse
queue_full_o  out  1  count == DEPTH

Behaviour:
- Reset (reset_n=0 at clk edge):
  - pc_o=RESET_PC, fetch_valid_o=0, flush_o=0, miss_pred_o=0.
  - Queue empty with pointers=0; counter=WNT (2'b01).
  - fetch_valid_o goes to 1 in the first cycle after reset is released.
  - Reset mid-operation discards all queue contents.
- Counter FSM: SNT(00) <-> WNT(01) <-> WT(10) <-> ST(11).
  - Resolved taken moves it up one state; resolved not-taken moves it down one state; it saturates at both ends.
  - Unconditional entries never update it.
- taken_pred_o = pred_is_branch_i & (pred_uncond_i | counter[1]). The output is combinational.
- Advance condition: fetch_valid_o & fetch_ready_i & ~stall_i & ~(pred_is_branch_i & queue_full_o).
  - Full blocks a branch fetch even if a pop occurs in the same cycle (conservative).
- On advance: next pc = taken_pred_o ? pred_target_i : pc_o+4.
  - If pred_is_branch_i, push {pred_taken, uncond, pred_target_i, pc_o+4}.
- No advance: pc_o holds.
- Resolve: res_valid_i with queue non-empty pops the head.
  - actual = res_taken_i ? res_target_i : fallthrough.
  - predicted = pred_taken ? pred_target : fallthrough.
  - Mismatch is actual != predicted, comparing full 32-bit values.
- Mispredict at cycle N:
  - At N+1, pc_o=actual, flush_o=1, miss_pred_o=1, queue cleared (count=0).
  - Any advance/push in cycle N is discarded; redirect has priority over stall_i.
- Correct prediction: pop only, no flush.
- Simultaneous push and correct pop: count unchanged, both pointers advance.
- res_valid_i with empty queue: ignored, with no state change.
- PC arithmetic is 32-bit modulo; wrap is ignored. Queue pointers are log2(DEPTH) bits and wrap naturally.
- Latency: next PC registered 1 cycle; redirect penalty 1 cycle after resolve.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs stat_branches_o[31:0] (resolves popped) and stat_misses_o[31:0] (mispredicts). Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour is identical.

Decomposition:
- Shared package/header: counter state encodings SNT/WNT/WT/ST and the queue entry field widths/offsets.
- Natural sub-module: br_pred_queue (DEPTH FIFO with push/pop/clear, full/empty/count). The PC mux and counter FSM stay in the top module.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with RESET_PC=0x100 -> pc_o=0x100, fetch_valid_o=0; release -> fetch_valid_o=1, sequential 0x104, 0x108 with fetch_ready_i=1.
- Counter at WNT, branch fetched at 0x200 with target 0x180 -> taken_pred_o=0, next pc 0x204. Resolve not-taken -> no flush, counter to SNT.
- Counter at WT, branch at 0x300 with target 0x400 -> pc 0x400. Resolve res_taken_i=0 -> next cycle flush_o=1, miss_pred_o=1, pc_o=0x304, queue empty, counter WNT.
- JAL at 0x40 with target 0x80 and counter SNT -> predicted taken, pc 0x80. Resolve taken to 0x80 -> no flush, counter stays SNT.
- Fill DEPTH=4 branches without resolving -> queue_full_o=1; fifth branch with fetch_ready_i=1 -> pc_o holds. Non-branch sequential fetch still advances; one resolve unblocks.
- Misprediction with stall_i=1 and a simultaneous push -> redirect wins, pushed entry discarded, count=0.
